// File: rtl/instr_prefetch_buffer.sv
// Purpose: fetch stage that prefetches instruction words over req/gnt/rvalid and queues {pc, word} for decode.
// Latency: grant at N, rvalid at N+k, instr_valid at N+k+1 (response is registered before decode sees it).
// Backpressure: decode stalls via instr_ready; requests stop once buffered + outstanding fetches reach DEPTH.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   redirect_valid/_pc         flush buffer, discard in-flight responses, restart fetch at redirect_pc
//   mem_req/_addr/_gnt         fetch request channel (address held while waiting for grant)
//   mem_rvalid/_rdata          in-order responses, one per granted request
//   instr_valid/_ready         decode handshake on the FIFO head
//   instr, instr_pc            head instruction word and its PC
module instr_prefetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   fifo_pc_q [DEPTH];
   logic [31:0]   fifo_pc_d [DEPTH];
   logic [31:0]   fifo_word_q [DEPTH];
   logic [31:0]   fifo_word_d [DEPTH];
   logic [31:0]   ipc_q [DEPTH];
   logic [31:0]   ipc_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] ipc_wr_q, ipc_wr_d, ipc_rd_q, ipc_rd_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_q, drop_d;

   logic credit_ok, gnt_fire, rsp_fire, push, pop;
   logic unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Credit rule: every granted fetch already owns a FIFO slot, so a push can never find the FIFO full.
   assign credit_ok   = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_S;
   assign mem_req     = !reset && !redirect_valid && credit_ok;
   assign mem_addr    = fetch_pc_q;
   assign gnt_fire    = mem_req && mem_gnt;
   // A response with nothing outstanding is a bus protocol violation and is ignored entirely.
   assign rsp_fire    = mem_rvalid && (outstanding_q != '0);
   assign push        = rsp_fire && (drop_q == '0) && !redirect_valid;
   assign instr_valid = (count_q != '0);
   assign pop         = instr_valid && instr_ready && !redirect_valid;
   assign instr       = fifo_word_q[rd_ptr_q];
   assign instr_pc    = fifo_pc_q[rd_ptr_q];

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      fifo_pc_d     = fifo_pc_q;
      fifo_word_d   = fifo_word_q;
      ipc_d         = ipc_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      ipc_wr_d      = ipc_wr_q;
      ipc_rd_d      = ipc_rd_q;
      count_d       = count_q;
      drop_d        = drop_q;
      outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(rsp_fire);

      // The in-flight PC queue tracks every outstanding request, including ones that will be dropped,
      // so it stays aligned with the response stream across redirects.
      if (gnt_fire) begin
         ipc_d[ipc_wr_q] = fetch_pc_q;
         ipc_wr_d        = ipc_wr_q + PW'(1);
      end
      if (rsp_fire) begin
         ipc_rd_d = ipc_rd_q + PW'(1);
      end

      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         // Everything still in flight after this cycle belongs to the old stream; drop_q is a subset of it.
         drop_d     = outstanding_q - CW'(rsp_fire);
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (rsp_fire && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
         if (push) begin
            fifo_pc_d[wr_ptr_q]   = ipc_q[ipc_rd_q];
            fifo_word_d[wr_ptr_q] = mem_rdata;
            wr_ptr_d              = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         ipc_wr_q      <= '0;
         ipc_rd_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         ipc_wr_q      <= ipc_wr_d;
         ipc_rd_q      <= ipc_rd_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   // Storage arrays need no reset: contents are only observed behind count/outstanding.
   always_ff @(posedge clk) begin
      fifo_pc_q   <= fifo_pc_d;
      fifo_word_q <= fifo_word_d;
      ipc_q       <= ipc_d;
   end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
module tb_instr_prefetch_buffer;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TAG      = 32'hA000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   always #5 clk = ~clk;

   instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int lat   = 1;

   // Memory model: in-order responses, lat cycles after the grant, rdata = addr | TAG.
   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;
   pend_t pend[$];

   typedef struct {
      logic        rst;
      logic        g;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;
   vec_t vt[$];

   logic        o_req, o_valid;
   logic [31:0] o_addr, o_pc, o_instr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle, entered and left at a negedge. Outputs are sampled 1 ns after inputs settle.
   task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc,
                        input logic g, input logic rdy);
      pend_t p;
      reset          = rst;
      redirect_valid = rv;
      redirect_pc    = rpc;
      mem_gnt        = g;
      instr_ready    = rdy;
      mem_rvalid     = 1'b0;
      mem_rdata      = 32'h0;
      if (rst) begin
         pend.delete();
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
         mem_rvalid = 1'b1;
         mem_rdata  = pend[0].addr | TAG;
         void'(pend.pop_front());
      end
      #1;
      o_req   = mem_req;
      o_addr  = mem_addr;
      o_valid = instr_valid;
      o_pc    = instr_pc;
      o_instr = instr;
      if (!rst && mem_req && g) begin
         p.addr = mem_addr;
         p.due  = cyc + lat;
         pend.push_back(p);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic add_vec(input logic rst, input logic g, input logic rdy, input logic e_req,
                          input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_pc);
      vec_t v;
      v.rst = rst; v.g = g; v.rdy = rdy; v.e_req = e_req;
      v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
      vt.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
      $fatal(1);
   end

   initial begin
      logic [31:0] seen[$];
      int          bad;

      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; instr_ready = 1'b0;

      // Streaming with gnt=1 and ready=1: first instr two cycles after the first grant.
      add_vec(1, 1, 1, 0, 32'h00, 0, 32'h00);
      add_vec(0, 1, 1, 1, 32'h00, 0, 32'h00);
      add_vec(0, 1, 1, 1, 32'h04, 0, 32'h00);
      add_vec(0, 1, 1, 1, 32'h08, 1, 32'h00);
      add_vec(0, 1, 1, 1, 32'h0C, 1, 32'h04);
      add_vec(0, 1, 1, 1, 32'h10, 1, 32'h08);
      // Decode stalled: exactly four grants, then requests stop; releasing ready drains in order.
      add_vec(1, 1, 0, 0, 32'h00, 0, 32'h00);
      add_vec(0, 1, 0, 1, 32'h00, 0, 32'h00);
      add_vec(0, 1, 0, 1, 32'h04, 0, 32'h00);
      add_vec(0, 1, 0, 1, 32'h08, 1, 32'h00);
      add_vec(0, 1, 0, 1, 32'h0C, 1, 32'h00);
      add_vec(0, 1, 0, 0, 32'h10, 1, 32'h00);
      add_vec(0, 1, 0, 0, 32'h10, 1, 32'h00);
      add_vec(0, 1, 1, 0, 32'h10, 1, 32'h00);
      add_vec(0, 1, 1, 1, 32'h10, 1, 32'h04);
      add_vec(0, 1, 1, 1, 32'h14, 1, 32'h08);
      add_vec(0, 1, 1, 1, 32'h18, 1, 32'h0C);
      add_vec(0, 1, 1, 1, 32'h1C, 1, 32'h10);
      // Grant withheld: request and address hold, nothing presented.
      add_vec(1, 0, 1, 0, 32'h00, 0, 32'h00);
      for (int k = 0; k < 5; k++) add_vec(0, 0, 1, 1, 32'h00, 0, 32'h00);

      @(negedge clk);
      lat = 1;
      for (int i = 0; i < vt.size(); i++) begin
         cycle(vt[i].rst, 1'b0, 32'h0, vt[i].g, vt[i].rdy);
         check($sformatf("vec%0d mem_req", i), {31'b0, o_req}, {31'b0, vt[i].e_req});
         if (!vt[i].rst) begin
            check($sformatf("vec%0d mem_addr", i), o_addr, vt[i].e_addr);
            check($sformatf("vec%0d instr_valid", i), {31'b0, o_valid}, {31'b0, vt[i].e_valid});
            if (vt[i].e_valid) begin
               check($sformatf("vec%0d instr_pc", i), o_pc, vt[i].e_pc);
               check($sformatf("vec%0d instr", i), o_instr, vt[i].e_pc | TAG);
            end
         end
      end

      // Redirect to 0x103 with two responses (0x0, 0x4) still in flight: both must be dropped.
      lat = 3;
      cycle(1, 0, 32'h0, 1, 1);
      cycle(0, 0, 32'h0, 1, 1);
      cycle(0, 0, 32'h0, 1, 1);
      cycle(0, 1, 32'h103, 1, 1);
      check("redir3 mem_req in redirect cycle", {31'b0, o_req}, 32'h0);
      cycle(0, 0, 32'h0, 1, 1);
      check("redir3 mem_addr after", o_addr, 32'h100);
      check("redir3 instr_valid after", {31'b0, o_valid}, 32'h0);
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         cycle(0, 0, 32'h0, 1, 1);
         if (o_valid) begin
            seen.push_back(o_pc);
            if (o_pc == 32'h0 || o_pc == 32'h4) bad++;
            if (seen.size() == 1) check("redir3 first instr", o_instr, 32'hA000_0100);
         end
      end
      check("redir3 stale pcs presented", bad, 0);
      check("redir3 presented count >= 2", {31'b0, seen.size() >= 2}, 32'h1);
      if (seen.size() >= 2) begin
         check("redir3 first pc", seen[0], 32'h100);
         check("redir3 second pc", seen[1], 32'h104);
      end

      // Redirect in the same cycle as an rvalid (0x8) and a pop (pc 0x4); 0xC is then dropped.
      lat = 2;
      cycle(1, 0, 32'h0, 1, 1);
      for (int k = 0; k < 4; k++) cycle(0, 0, 32'h0, 1, 1);
      cycle(0, 1, 32'h200, 1, 1);
      check("redir5 mem_req in redirect cycle", {31'b0, o_req}, 32'h0);
      check("redir5 pre valid", {31'b0, o_valid}, 32'h1);
      check("redir5 pre pc", o_pc, 32'h4);
      cycle(0, 0, 32'h0, 1, 1);
      check("redir5 valid +1", {31'b0, o_valid}, 32'h0);
      check("redir5 mem_req +1", {31'b0, o_req}, 32'h1);
      check("redir5 mem_addr +1", o_addr, 32'h200);
      cycle(0, 0, 32'h0, 1, 1);
      check("redir5 valid +2", {31'b0, o_valid}, 32'h0);
      cycle(0, 0, 32'h0, 1, 1);
      check("redir5 valid +3", {31'b0, o_valid}, 32'h0);
      cycle(0, 0, 32'h0, 1, 1);
      check("redir5 valid +4", {31'b0, o_valid}, 32'h1);
      check("redir5 pc +4", o_pc, 32'h200);
      check("redir5 instr +4", o_instr, 32'hA000_0200);

      // Reset pulsed while the FIFO holds three entries and one fetch is in flight.
      lat = 1;
      cycle(1, 0, 32'h0, 1, 0);
      for (int k = 0; k < 4; k++) cycle(0, 0, 32'h0, 1, 0);
      check("rst6 pre valid", {31'b0, o_valid}, 32'h1);
      cycle(1, 0, 32'h0, 1, 0);
      check("rst6 mem_req during reset", {31'b0, o_req}, 32'h0);
      cycle(0, 0, 32'h0, 1, 1);
      check("rst6 valid after", {31'b0, o_valid}, 32'h0);
      check("rst6 mem_addr after", o_addr, RESET_PC);
      check("rst6 mem_req after", {31'b0, o_req}, 32'h1);
      cycle(0, 0, 32'h0, 1, 1);
      check("rst6 mem_addr +1", o_addr, 32'h4);
      cycle(0, 0, 32'h0, 1, 1);
      check("rst6 valid +2", {31'b0, o_valid}, 32'h1);
      check("rst6 pc +2", o_pc, RESET_PC);
      check("rst6 instr +2", o_instr, RESET_PC | TAG);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
